clause_credit_scheduler: RTL

Credit-based round-robin scheduler between the clause latency buffer and the per-engine clause queues. It replaces full-signal backpressure with per-engine credit counters. It hands out one clause per cycle to the next engine with free queue space, and tracks outstanding clauses so it can signal when the engines have drained a distribution phase. It sits in the arbiter layer, upstream of the `NUM_ENGINE` BCP engines.

---
 rtl/clause_credit_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/clause_credit_scheduler.sv
// clause_credit_scheduler: credit-based round-robin dispatch of clauses into NUM_ENGINE engine queues.
// Optional unit-clause broadcast to all engines is built in when CCS_UC_BROADCAST_EN is defined.
//
// state | meaning
// IDLE  | waiting for start_in
// RUN   | dispatching clauses while any engine has credit
// DRAIN | final clause taken, waiting for every credit to come back
module clause_credit_scheduler #(
    parameter int NUM_ENGINE   = 4,
    parameter int CLA_WIDTH    = 33,
    parameter int CREDIT_DEPTH = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start_in,
    input  logic                            clause_valid_in,
    input  logic [CLA_WIDTH-1:0]            clause_in,
    input  logic                            last_in,
    output logic                            clause_ready_out,
    input  logic [NUM_ENGINE-1:0]           credit_return_in,
`ifdef CCS_UC_BROADCAST_EN
    input  logic                            uc_valid_in,
    input  logic [CLA_WIDTH-1:0]            uc_in,
    output logic                            uc_ready_out,
`endif
    output logic [NUM_ENGINE*CLA_WIDTH-1:0] clause_out,
    output logic [NUM_ENGINE-1:0]           grant_out,
    output logic                            busy_out,
    output logic                            done_out,
    output logic                            err_out
);

    localparam int CW = $clog2(CREDIT_DEPTH) + 1;
    localparam int PW = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
    localparam logic [CW-1:0] FULL = CW'(CREDIT_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cred     [NUM_ENGINE];
    logic [CW-1:0]         cred_nxt [NUM_ENGINE];
    logic [PW-1:0]         ptr, tgt, sel;
    logic [NUM_ENGINE-1:0] give, sat;
    logic [CLA_WIDTH-1:0]  wdata;
    logic                  any_cred, all_full_nxt, accept, bcast, uc_block, done_nxt;

`ifdef CCS_UC_BROADCAST_EN
    logic all_cred;

    always_comb begin
        all_cred = 1'b1;
        for (int i = 0; i < NUM_ENGINE; i++) begin
            if (cred[i] == '0) all_cred = 1'b0;
        end
    end

    assign uc_ready_out = (state != IDLE) && all_cred;
    assign bcast        = uc_valid_in && uc_ready_out;
    assign uc_block     = uc_valid_in;
    assign wdata        = bcast ? uc_in : clause_in;
`else
    assign bcast    = 1'b0;
    assign uc_block = 1'b0;
    assign wdata    = clause_in;
`endif

    always_comb begin
        any_cred = 1'b0;
        for (int i = 0; i < NUM_ENGINE; i++) begin
            if (cred[i] != '0) any_cred = 1'b1;
        end
    end

    // Walk downward so the last hit written is the nearest engine above the pointer.
    always_comb begin
        tgt = '0;
        sel = '0;
        for (int k = NUM_ENGINE - 1; k >= 0; k--) begin
            sel = PW'((int'(ptr) + k) % NUM_ENGINE);
            if (cred[sel] != '0) tgt = sel;
        end
    end

    assign accept = clause_valid_in && clause_ready_out;

    always_comb begin
        give = '0;
        if (bcast) give = '1;
        else if (accept) give[tgt] = 1'b1;
    end

    always_comb begin
        all_full_nxt = 1'b1;
        for (int i = 0; i < NUM_ENGINE; i++) begin
            cred_nxt[i] = cred[i];
            sat[i]      = 1'b0;
            if (give[i] && !credit_return_in[i]) begin
                cred_nxt[i] = cred[i] - CW'(1);
            end else if (!give[i] && credit_return_in[i]) begin
                if (cred[i] == FULL) sat[i] = 1'b1;
                else cred_nxt[i] = cred[i] + CW'(1);
            end
            if (cred_nxt[i] != FULL) all_full_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_in) state_nxt = RUN;
            RUN:     if (accept && last_in) state_nxt = DRAIN;
            DRAIN:   if (all_full_nxt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_out         = (state != IDLE);
        clause_ready_out = (state == RUN) && any_cred && !uc_block;
        done_nxt         = (state == DRAIN) && all_full_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENGINE; i++) cred[i] <= FULL;
            ptr        <= '0;
            grant_out  <= '0;
            clause_out <= '0;
            done_out   <= 1'b0;
            err_out    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENGINE; i++) begin
                cred[i] <= cred_nxt[i];
                if (give[i]) clause_out[i*CLA_WIDTH +: CLA_WIDTH] <= wdata;
            end
            grant_out <= give;
            done_out  <= done_nxt;
            if (|sat) err_out <= 1'b1;
            if (accept) ptr <= (tgt == PW'(NUM_ENGINE - 1)) ? '0 : tgt + PW'(1);
        end
    end

endmodule
